alu_sequencer: RTL and testbench

//  Initiator/controller side of the ALU interface (func/a/b/carry_in -> add/carry_out).

---
 rtl/alu_sequencer_if.sv | 58 +++++
 rtl/alu_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Request, response and ALU-side signal bundle for alu_sequencer.
// slave = sequencer view, master = decoder/ALU environment view.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef OPP_WIDTH
`define OPP_WIDTH 4
`endif
`ifndef SUM
`define SUM 4'b0001
`endif
`ifndef AND
`define AND 4'b0010
`endif
`ifndef OR
`define OR 4'b0100
`endif
`ifndef XOR
`define XOR 4'b1000
`endif

interface alu_sequencer_if;
  logic                  req_valid;
  logic                  req_ready;
  logic [3:0]            req_op;
  logic [`REG_WIDTH-1:0] req_a;
  logic [`REG_WIDTH-1:0] req_b;
  logic                  req_c;
  logic                  req_d;
  logic [`OPP_WIDTH-1:0] alu_func;
  logic [`REG_WIDTH-1:0] alu_a;
  logic [`REG_WIDTH-1:0] alu_b;
  logic                  alu_carry_in;
  logic [`REG_WIDTH-1:0] alu_add;
  logic                  alu_carry_out;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [`REG_WIDTH-1:0] rsp_result;
  logic                  rsp_n;
  logic                  rsp_z;
  logic                  rsp_c;
  logic                  rsp_v;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_c, req_d,
           alu_add, alu_carry_out, rsp_ready,
    output req_ready, alu_func, alu_a, alu_b, alu_carry_in,
           rsp_valid, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_c, req_d,
           alu_add, alu_carry_out, rsp_ready,
    input  req_ready, alu_func, alu_a, alu_b, alu_carry_in,
           rsp_valid, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Translates 6502 ops into one-hot ALU commands, waits ALU_LATENCY cycles, returns N/Z/C/V.
// Optional DECIMAL_MODE_EN adds a FIX state applying BCD correction to ADC/SBC with req_d=1.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef OPP_WIDTH
`define OPP_WIDTH 4
`endif
`ifndef SUM
`define SUM 4'b0001
`endif
`ifndef AND
`define AND 4'b0010
`endif
`ifndef OR
`define OR 4'b0100
`endif
`ifndef XOR
`define XOR 4'b1000
`endif

module alu_sequencer #(
  parameter int unsigned ALU_LATENCY = 1
) (
  input logic            phi1,
  input logic            reset_n,
  alu_sequencer_if.slave bus
);
  localparam int unsigned CW = $clog2(ALU_LATENCY + 1);

`ifdef DECIMAL_MODE_EN
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FIX, S_RESP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
`endif
  typedef enum logic [3:0] {
    OP_ADC = 4'd0, OP_SBC, OP_AND, OP_ORA, OP_EOR, OP_ASL, OP_CMP, OP_INC, OP_DEC
  } op_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            op_q, op_d;
  logic [`REG_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  c_q, c_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [`REG_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                  rsp_n_q, rsp_n_d, rsp_z_q, rsp_z_d, rsp_c_q, rsp_c_d;
  logic                  rsp_v_q, rsp_v_d, rsp_err_q, rsp_err_d;
`ifdef DECIMAL_MODE_EN
  logic                  dec_q, dec_d;
  logic [5:0]            lo, hi;
  logic [`REG_WIDTH-1:0] fixed;
`else
  logic                  unused_req_d;
  assign unused_req_d = bus.req_d;
`endif

  logic [`OPP_WIDTH-1:0] alu_f;
  logic [`REG_WIDTH-1:0] alu_x, alu_y;
  logic                  alu_ci;
  logic                  exec, legal, carry_op, arith;

  always_comb begin
    alu_f  = '0;
    alu_x  = a_q;
    alu_y  = b_q;
    alu_ci = 1'b0;
    case (op_q)
      OP_ADC: begin alu_f = `SUM; alu_ci = c_q; end
      OP_SBC: begin alu_f = `SUM; alu_y = ~b_q; alu_ci = c_q; end
      OP_AND: alu_f = `AND;
      OP_ORA: alu_f = `OR;
      OP_EOR: alu_f = `XOR;
      OP_ASL: begin alu_f = `SUM; alu_y = a_q; end
      OP_CMP: begin alu_f = `SUM; alu_y = ~b_q; alu_ci = 1'b1; end
      OP_INC: begin alu_f = `SUM; alu_y = '0; alu_ci = 1'b1; end
      OP_DEC: begin alu_f = `SUM; alu_y = '1; end
      default: begin alu_x = '0; alu_y = '0; end
    endcase
  end

  assign exec     = (state_q == S_EXEC);
  assign legal    = (op_q <= OP_DEC);
  assign arith    = (op_q == OP_ADC) || (op_q == OP_SBC);
  assign carry_op = arith || (op_q == OP_ASL) || (op_q == OP_CMP);

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.alu_func     = exec ? alu_f : '0;
  assign bus.alu_a        = exec ? alu_x : '0;
  assign bus.alu_b        = exec ? alu_y : '0;
  assign bus.alu_carry_in = exec & alu_ci;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_n        = rsp_n_q;
  assign bus.rsp_z        = rsp_z_q;
  assign bus.rsp_c        = rsp_c_q;
  assign bus.rsp_v        = rsp_v_q;
  assign bus.rsp_err      = rsp_err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_n_d      = rsp_n_q;
    rsp_z_d      = rsp_z_q;
    rsp_c_d      = rsp_c_q;
    rsp_v_d      = rsp_v_q;
    rsp_err_d    = rsp_err_q;
`ifdef DECIMAL_MODE_EN
    dec_d = dec_q;
    lo    = '0;
    hi    = '0;
    fixed = '0;
`endif
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        op_d    = bus.req_op;
        a_d     = bus.req_a;
        b_d     = bus.req_b;
        c_d     = bus.req_c;
`ifdef DECIMAL_MODE_EN
        dec_d   = bus.req_d;
`endif
        cnt_d   = CW'(ALU_LATENCY - 1);
        state_d = S_EXEC;
      end
      S_EXEC: if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
        if (legal) begin
          rsp_result_d = bus.alu_add;
          rsp_c_d      = carry_op ? bus.alu_carry_out : c_q;
          rsp_v_d      = arith && (alu_x[7] == alu_y[7]) && (bus.alu_add[7] != alu_x[7]);
          rsp_err_d    = 1'b0;
        end else begin
          rsp_result_d = a_q;
          rsp_c_d      = c_q;
          rsp_v_d      = 1'b0;
          rsp_err_d    = 1'b1;
        end
        rsp_n_d = rsp_result_d[7];
        rsp_z_d = (rsp_result_d == '0);
`ifdef DECIMAL_MODE_EN
        if (dec_q && arith) begin
          state_d     = S_FIX;
          rsp_valid_d = 1'b0;
        end
`endif
      end
`ifdef DECIMAL_MODE_EN
      // ADC is rebuilt nibble-wise from the operands; SBC corrects the latched binary result.
      S_FIX: begin
        if (op_q == OP_ADC) begin
          lo = {2'b0, a_q[3:0]} + {2'b0, b_q[3:0]} + {5'b0, c_q};
          if (lo > 6'd9) lo = lo + 6'd6;
          hi = {2'b0, a_q[7:4]} + {2'b0, b_q[7:4]} + {5'b0, (lo > 6'd15)};
          if (hi > 6'd9) hi = hi + 6'd6;
          fixed   = {hi[3:0], lo[3:0]};
          rsp_c_d = (hi > 6'd15);
        end else begin
          fixed = rsp_result_q;
          if ({1'b0, a_q[3:0]} < ({1'b0, b_q[3:0]} + {4'b0, ~c_q})) fixed = fixed - 8'h06;
          if (!rsp_c_q) fixed = fixed - 8'h60;
        end
        rsp_result_d = fixed;
        rsp_n_d      = fixed[7];
        rsp_z_d      = (fixed == '0);
        rsp_valid_d  = 1'b1;
        state_d      = S_RESP;
      end
`endif
      S_RESP: if (bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_n_q      <= 1'b0;
      rsp_z_q      <= 1'b0;
      rsp_c_q      <= 1'b0;
      rsp_v_q      <= 1'b0;
      rsp_err_q    <= 1'b0;
`ifdef DECIMAL_MODE_EN
      dec_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_n_q      <= rsp_n_d;
      rsp_z_q      <= rsp_z_d;
      rsp_c_q      <= rsp_c_d;
      rsp_v_q      <= rsp_v_d;
      rsp_err_q    <= rsp_err_d;
`ifdef DECIMAL_MODE_EN
      dec_q        <= dec_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: arithmetic reference model, per-cycle compare, directed and random ops.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef OPP_WIDTH
`define OPP_WIDTH 4
`endif
`ifndef SUM
`define SUM 4'b0001
`endif
`ifndef AND
`define AND 4'b0010
`endif
`ifndef OR
`define OR 4'b0100
`endif
`ifndef XOR
`define XOR 4'b1000
`endif

module tb_alu_sequencer;
  localparam int unsigned LAT = 2;

  logic phi1    = 1'b0;
  logic reset_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  always #5 phi1 = ~phi1;

  alu_sequencer_if ifc();
  alu_sequencer #(.ALU_LATENCY(LAT)) dut (.phi1(phi1), .reset_n(reset_n), .bus(ifc));

  // Combinational ALU standing in for the real one.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    case (ifc.alu_func)
      `SUM: alu_sum = {1'b0, ifc.alu_a} + {1'b0, ifc.alu_b} + {8'b0, ifc.alu_carry_in};
      `AND: alu_sum = {1'b0, ifc.alu_a & ifc.alu_b};
      `OR:  alu_sum = {1'b0, ifc.alu_a | ifc.alu_b};
      `XOR: alu_sum = {1'b0, ifc.alu_a ^ ifc.alu_b};
      default: alu_sum = '0;
    endcase
    ifc.alu_add       = alu_sum[7:0];
    ifc.alu_carry_out = alu_sum[8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] pk(input logic e, n, z, c, v, input logic [7:0] r);
    return {e, n, z, c, v, r};
  endfunction

  // Expected response {err,n,z,c,v,result} from 6502 arithmetic.
  function automatic logic [12:0] ref_rsp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                          input logic c, input logic d);
    int ai, bi, ci, sa, sb, r, t, lo, hi;
    logic cy, v, err;
    ai = int'(a); bi = int'(b); ci = int'(c);
    sa = (ai >= 128) ? ai - 256 : ai;
    sb = (bi >= 128) ? bi - 256 : bi;
    cy = c; v = 1'b0; err = 1'b0; r = ai;
    case (op)
      4'd0: begin
        r = ai + bi + ci; cy = (r > 255);
        t = sa + sb + ci; v = (t > 127) || (t < -128);
`ifdef DECIMAL_MODE_EN
        if (d) begin
          lo = ai % 16 + bi % 16 + ci; if (lo > 9) lo += 6;
          hi = ai / 16 + bi / 16 + ((lo > 15) ? 1 : 0); if (hi > 9) hi += 6;
          cy = (hi > 15); r = (hi % 16) * 16 + lo % 16;
        end
`endif
      end
      4'd1: begin
        r = ai - bi - (1 - ci); cy = (ai >= bi + 1 - ci);
        t = sa - sb - (1 - ci); v = (t > 127) || (t < -128);
`ifdef DECIMAL_MODE_EN
        if (d) begin
          if (ai % 16 < bi % 16 + 1 - ci) r -= 6;
          if (!cy) r -= 96;
        end
`endif
      end
      4'd2: r = ai & bi;
      4'd3: r = ai | bi;
      4'd4: r = ai ^ bi;
      4'd5: begin r = ai * 2; cy = a[7]; end
      4'd6: begin r = ai - bi; cy = (ai >= bi); end
      4'd7: r = ai + 1;
      4'd8: r = ai - 1;
      default: err = 1'b1;
    endcase
    r = r & 255;
    lo = int'(d);
    return {err, r[7], (r == 0), cy, v, r[7:0]};
  endfunction

  // Expected ALU drive {func,a,b,cin} while the op is executing.
  function automatic logic [20:0] alu_exp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                          input logic c);
    case (op)
      4'd0: return {`SUM, a, b, c};
      4'd1: return {`SUM, a, 8'(255 - int'(b)), c};
      4'd2: return {`AND, a, b, 1'b0};
      4'd3: return {`OR,  a, b, 1'b0};
      4'd4: return {`XOR, a, b, 1'b0};
      4'd5: return {`SUM, a, a, 1'b0};
      4'd6: return {`SUM, a, 8'(255 - int'(b)), 1'b1};
      4'd7: return {`SUM, a, 8'h00, 1'b1};
      4'd8: return {`SUM, a, 8'hFF, 1'b0};
      default: return '0;
    endcase
  endfunction

  // Transaction model: accepted op, cycles since accept, cycles until response.
  logic        m_busy = 1'b0;
  int          m_age  = 0;
  int          m_lat  = 0;
  logic [3:0]  m_op;
  logic [7:0]  m_a, m_b;
  logic        m_c;
  logic [12:0] m_rsp;

  always @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (ifc.req_valid) begin
        m_busy = 1'b1; m_age = 1;
        m_op = ifc.req_op; m_a = ifc.req_a; m_b = ifc.req_b; m_c = ifc.req_c;
        m_rsp = ref_rsp(ifc.req_op, ifc.req_a, ifc.req_b, ifc.req_c, ifc.req_d);
        m_lat = int'(LAT);
`ifdef DECIMAL_MODE_EN
        if (ifc.req_d && ifc.req_op < 4'd2) m_lat = int'(LAT) + 1;
`endif
      end
    end else if (m_age > m_lat && ifc.rsp_ready) begin
      m_busy = 1'b0;
    end else begin
      m_age++;
    end
  end

  always @(negedge phi1) begin
    logic exp_valid, in_exec;
    exp_valid = m_busy && (m_age > m_lat);
    in_exec   = m_busy && (m_age <= int'(LAT));
    chk("req_ready", {31'b0, ifc.req_ready}, {31'b0, !m_busy});
    chk("rsp_valid", {31'b0, ifc.rsp_valid}, {31'b0, exp_valid});
    if (in_exec)
      chk("alu_drive", {11'b0, ifc.alu_func, ifc.alu_a, ifc.alu_b, ifc.alu_carry_in},
          {11'b0, alu_exp(m_op, m_a, m_b, m_c)});
    else
      chk("alu_idle", {11'b0, ifc.alu_func, ifc.alu_a, ifc.alu_b, ifc.alu_carry_in}, 32'b0);
    if (exp_valid)
      chk("rsp_fields", {19'b0, ifc.rsp_err, ifc.rsp_n, ifc.rsp_z, ifc.rsp_c, ifc.rsp_v, ifc.rsp_result},
          {19'b0, m_rsp});
  end

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic d, input int hold,
                        output logic [12:0] got, output logic [20:0] drv, output int lat);
    int n;
    got = '0; drv = '0; lat = -1; n = 0;
    while (!ifc.req_ready && n < 20) begin @(negedge phi1); n++; end
    @(posedge phi1); #1;
    ifc.req_valid = 1'b1; ifc.req_op = op; ifc.req_a = a; ifc.req_b = b;
    ifc.req_c = c; ifc.req_d = d; ifc.rsp_ready = 1'b0;
    @(posedge phi1); #1;
    ifc.req_valid = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge phi1);
      if (n == 1) drv = {ifc.alu_func, ifc.alu_a, ifc.alu_b, ifc.alu_carry_in};
      if (ifc.rsp_valid) begin
        lat = n - 1;
        got = {ifc.rsp_err, ifc.rsp_n, ifc.rsp_z, ifc.rsp_c, ifc.rsp_v, ifc.rsp_result};
        break;
      end
    end
    if (lat < 0) chk("rsp_timeout", 32'd0, 32'd1);
    repeat (hold) @(negedge phi1);
    @(posedge phi1); #1; ifc.rsp_ready = 1'b1;
    @(posedge phi1); #1; ifc.rsp_ready = 1'b0;
  endtask

  logic [12:0] got, lit;
  logic [20:0] drv;
  int          lat;

  initial begin
    ifc.req_valid = 1'b0; ifc.req_op = '0; ifc.req_a = '0; ifc.req_b = '0;
    ifc.req_c = 1'b0; ifc.req_d = 1'b0; ifc.rsp_ready = 1'b0;
    repeat (2) @(negedge phi1);
    chk("reset_ready", {31'b0, ifc.req_ready}, 32'd1);
    chk("reset_rsp", {19'b0, ifc.rsp_valid, ifc.rsp_err, ifc.rsp_n, ifc.rsp_z, ifc.rsp_c, ifc.rsp_v,
                      ifc.rsp_result}, 32'd0);
    chk("reset_alu", {11'b0, ifc.alu_func, ifc.alu_a, ifc.alu_b, ifc.alu_carry_in}, 32'd0);
    @(posedge phi1); #1; reset_n = 1'b1;

    lit = pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0);
    chk("model_adc", {19'b0, ref_rsp(4'd0, 8'h50, 8'h50, 1'b0, 1'b0)}, {19'b0, lit});
    run_op(4'd0, 8'h50, 8'h50, 1'b0, 1'b0, 0, got, drv, lat);
    chk("dut_adc", {19'b0, got}, {19'b0, lit});
    chk("adc_func", {28'b0, drv[20:17]}, {28'b0, `SUM});
    chk("adc_latency", lat, LAT);

    lit = pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
    chk("model_sbc", {19'b0, ref_rsp(4'd1, 8'h05, 8'h06, 1'b1, 1'b0)}, {19'b0, lit});
    run_op(4'd1, 8'h05, 8'h06, 1'b1, 1'b0, 0, got, drv, lat);
    chk("dut_sbc", {19'b0, got}, {19'b0, lit});
    chk("sbc_drive", {11'b0, drv}, {11'b0, `SUM, 8'h05, 8'hF9, 1'b1});

    lit = pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("model_cmp", {19'b0, ref_rsp(4'd6, 8'h40, 8'h40, 1'b0, 1'b0)}, {19'b0, lit});
    run_op(4'd6, 8'h40, 8'h40, 1'b0, 1'b0, 0, got, drv, lat);
    chk("dut_cmp", {19'b0, got}, {19'b0, lit});

    lit = pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02);
    chk("model_asl", {19'b0, ref_rsp(4'd5, 8'h81, 8'h00, 1'b0, 1'b0)}, {19'b0, lit});
    run_op(4'd5, 8'h81, 8'h00, 1'b0, 1'b0, 0, got, drv, lat);
    chk("dut_asl", {19'b0, got}, {19'b0, lit});

    lit = pk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
    chk("model_dec", {19'b0, ref_rsp(4'd8, 8'h00, 8'h00, 1'b1, 1'b0)}, {19'b0, lit});
    run_op(4'd8, 8'h00, 8'h00, 1'b1, 1'b0, 0, got, drv, lat);
    chk("dut_dec", {19'b0, got}, {19'b0, lit});

    // Illegal op with response held off for 5 cycles.
    lit = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C);
    chk("model_ill", {19'b0, ref_rsp(4'hF, 8'h3C, 8'h77, 1'b0, 1'b0)}, {19'b0, lit});
    run_op(4'hF, 8'h3C, 8'h77, 1'b0, 1'b0, 5, got, drv, lat);
    chk("dut_ill", {19'b0, got}, {19'b0, lit});
    chk("ill_func", {28'b0, drv[20:17]}, 32'd0);

`ifdef DECIMAL_MODE_EN
    lit = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h47);
`else
    lit = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41);
`endif
    chk("model_bcd1", {19'b0, ref_rsp(4'd0, 8'h19, 8'h28, 1'b0, 1'b1)}, {19'b0, lit});
    run_op(4'd0, 8'h19, 8'h28, 1'b0, 1'b1, 0, got, drv, lat);
    chk("dut_bcd1", {19'b0, got}, {19'b0, lit});
`ifdef DECIMAL_MODE_EN
    chk("bcd_latency", lat, LAT + 1);
    lit = pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
`else
    chk("bcd_latency", lat, LAT);
    lit = pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h9A);
`endif
    chk("model_bcd2", {19'b0, ref_rsp(4'd0, 8'h99, 8'h01, 1'b0, 1'b1)}, {19'b0, lit});
    run_op(4'd0, 8'h99, 8'h01, 1'b0, 1'b1, 0, got, drv, lat);
    chk("dut_bcd2", {19'b0, got}, {19'b0, lit});

    // Reset pulsed while executing: the op must vanish.
    @(posedge phi1); #1;
    ifc.req_valid = 1'b1; ifc.req_op = 4'd0; ifc.req_a = 8'h12; ifc.req_b = 8'h34;
    @(posedge phi1); #1;
    ifc.req_valid = 1'b0; ifc.rsp_ready = 1'b1; reset_n = 1'b0;
    repeat (2) @(posedge phi1);
    #1 reset_n = 1'b1;
    @(negedge phi1);
    chk("ready_after_reset", {31'b0, ifc.req_ready}, 32'd1);
    repeat (4) begin
      @(negedge phi1);
      chk("no_rsp_after_reset", {31'b0, ifc.rsp_valid}, 32'd0);
    end

    // Random traffic: req_valid toggles freely, busy-time requests must be ignored.
    for (int i = 0; i < 800; i++) begin
      @(posedge phi1); #1;
      ifc.req_valid = ($urandom_range(0, 1) == 1);
      ifc.req_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      ifc.req_a     = 8'($urandom);
      ifc.req_b     = 8'($urandom);
      ifc.req_c     = 1'($urandom);
      ifc.req_d     = 1'($urandom);
      ifc.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    ifc.req_valid = 1'b0; ifc.rsp_ready = 1'b1;
    for (int k = 0; k < 30 && m_busy; k++) @(negedge phi1);
    chk("drain", {31'b0, m_busy}, 32'd0);

    repeat (2) @(negedge phi1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
